// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename tags and commit bypass
module reg_rename_file #(
  parameter int REG_NUM   = 32,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 Dis_flag,
  input  logic                 Dis_rd_flag,
  input  logic [4:0]           Dis_rd,
  input  logic [ROB_IDX_W-1:0] Dis_ROB_idx,
  input  logic [4:0]           Dis_rs1,
  input  logic [4:0]           Dis_rs2,
  output logic                 Dis_busy1,
  output logic [ROB_IDX_W-1:0] Dis_tag1,
  output logic [31:0]          Dis_val1,
  output logic                 Dis_busy2,
  output logic [ROB_IDX_W-1:0] Dis_tag2,
  output logic [31:0]          Dis_val2,
  input  logic                 RF_write_flag,
  input  logic [4:0]           RF_rd,
  input  logic [ROB_IDX_W-1:0] RF_ROB_idx,
  input  logic [31:0]          RF_val,
  input  logic                 ROB_roll
);
  logic [31:0]          val_q [REG_NUM];
  logic [31:0]          val_d [REG_NUM];
  logic [ROB_IDX_W-1:0] tag_q [REG_NUM];
  logic [ROB_IDX_W-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q, busy_d;
  logic                 commit, rename, byp1, byp2, nz1, nz2;
  assign commit = rdy && RF_write_flag && RF_rd != '0;
  assign rename = rdy && Dis_flag && Dis_rd_flag && Dis_rd != '0 && !ROB_roll;
  // operand read: x0 reads zero, a matching commit this cycle is forwarded, otherwise current state
  always_comb begin
    nz1       = Dis_rs1 != '0;
    nz2       = Dis_rs2 != '0;
    byp1      = RF_write_flag && RF_rd == Dis_rs1 && busy_q[Dis_rs1] && tag_q[Dis_rs1] == RF_ROB_idx;
    byp2      = RF_write_flag && RF_rd == Dis_rs2 && busy_q[Dis_rs2] && tag_q[Dis_rs2] == RF_ROB_idx;
    Dis_busy1 = nz1 && busy_q[Dis_rs1] && !byp1;
    Dis_busy2 = nz2 && busy_q[Dis_rs2] && !byp2;
    Dis_tag1  = nz1 ? tag_q[Dis_rs1] : '0;
    Dis_tag2  = nz2 ? tag_q[Dis_rs2] : '0;
    Dis_val1  = !nz1 ? '0 : byp1 ? RF_val : val_q[Dis_rs1];
    Dis_val2  = !nz2 ? '0 : byp2 ? RF_val : val_q[Dis_rs2];
  end
  // next state: commit write/clear, then roll flush, then rename (rename wins over the commit clear)
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit) begin
      val_d[RF_rd] = RF_val;
      if (tag_q[RF_rd] == RF_ROB_idx) busy_d[RF_rd] = 1'b0;
    end
    if (rdy && ROB_roll) busy_d = '0;
    if (rename) begin
      busy_d[Dis_rd] = 1'b1;
      tag_d[Dis_rd]  = Dis_ROB_idx;
    end
  end
  // state registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end
endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: directed and random checks of reg_rename_file against a rule-level model
module tb_reg_rename_file;
  localparam int TW = 4;
  logic          clk = 1'b0;
  logic          rst, rdy, Dis_flag, Dis_rd_flag, RF_write_flag, ROB_roll;
  logic [4:0]    Dis_rd, Dis_rs1, Dis_rs2, RF_rd;
  logic [TW-1:0] Dis_ROB_idx, RF_ROB_idx, Dis_tag1, Dis_tag2;
  logic [31:0]   RF_val, Dis_val1, Dis_val2;
  logic          Dis_busy1, Dis_busy2;
  int            n_vec = 0, n_err = 0;
  logic [31:0]   m_val [32];
  logic [TW-1:0] m_tag [32];
  bit            m_busy [32];

  reg_rename_file #(.REG_NUM(32), .ROB_IDX_W(TW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .Dis_flag(Dis_flag), .Dis_rd_flag(Dis_rd_flag), .Dis_rd(Dis_rd), .Dis_ROB_idx(Dis_ROB_idx),
    .Dis_rs1(Dis_rs1), .Dis_rs2(Dis_rs2),
    .Dis_busy1(Dis_busy1), .Dis_tag1(Dis_tag1), .Dis_val1(Dis_val1),
    .Dis_busy2(Dis_busy2), .Dis_tag2(Dis_tag2), .Dis_val2(Dis_val2),
    .RF_write_flag(RF_write_flag), .RF_rd(RF_rd), .RF_ROB_idx(RF_ROB_idx), .RF_val(RF_val),
    .ROB_roll(ROB_roll)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rdy = 1; Dis_flag = 0; Dis_rd_flag = 0; Dis_rd = 0; Dis_ROB_idx = 0;
    RF_write_flag = 0; RF_rd = 0; RF_ROB_idx = 0; RF_val = 0; ROB_roll = 0;
    Dis_rs1 = 0; Dis_rs2 = 0;
  endtask

  task automatic ren(input logic [4:0] rd, input logic [TW-1:0] t);
    Dis_flag = 1; Dis_rd_flag = 1; Dis_rd = rd; Dis_ROB_idx = t;
  endtask

  task automatic cmt(input logic [4:0] rd, input logic [TW-1:0] t, input logic [31:0] v);
    RF_write_flag = 1; RF_rd = rd; RF_ROB_idx = t; RF_val = v;
  endtask

  task automatic check_src(input string nm, input logic [4:0] rs, input logic gb,
                           input logic [TW-1:0] gt, input logic [31:0] gv);
    bit fwd, eb;
    logic [31:0] ev;
    fwd = rs != 0 && RF_write_flag && RF_rd == rs && m_busy[rs] && m_tag[rs] == RF_ROB_idx;
    eb  = rs != 0 && m_busy[rs] && !fwd;
    ev  = rs == 0 ? 32'h0 : fwd ? RF_val : m_val[rs];
    chk({nm, "_busy"}, 32'(gb), 32'(eb));
    chk({nm, "_val"}, gv, ev);
    if (eb) chk({nm, "_tag"}, 32'(gt), 32'(m_tag[rs]));
  endtask

  task automatic look();
    #2;
    check_src("rs1", Dis_rs1, Dis_busy1, Dis_tag1, Dis_val1);
    check_src("rs2", Dis_rs2, Dis_busy2, Dis_tag2, Dis_val2);
  endtask

  task automatic adv();
    bit r;
    @(posedge clk);
    r = rdy && Dis_flag && Dis_rd_flag && Dis_rd != 0 && !ROB_roll;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0; end
    end else if (rdy) begin
      if (RF_write_flag && RF_rd != 0) begin
        m_val[RF_rd] = RF_val;
        if (m_tag[RF_rd] == RF_ROB_idx && !(r && Dis_rd == RF_rd)) m_busy[RF_rd] = 0;
      end
      if (ROB_roll) for (int i = 0; i < 32; i++) m_busy[i] = 0;
      if (r) begin m_busy[Dis_rd] = 1; m_tag[Dis_rd] = Dis_ROB_idx; end
    end
    #1;
  endtask

  task automatic tick();
    look();
    adv();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_tag[i] = 0; m_busy[i] = 0; end
    idle(); rst = 0;
    adv();
    rst = 1; Dis_rs1 = 5; Dis_rs2 = 31;
    look();
    chk("rst_b1", 32'(Dis_busy1), 0); chk("rst_v1", Dis_val1, 0);
    chk("rst_b2", 32'(Dis_busy2), 0); chk("rst_v2", Dis_val2, 0);
    adv();
    idle(); ren(3, 7); tick();
    idle(); Dis_rs1 = 3; look();
    chk("ren_b", 32'(Dis_busy1), 1); chk("ren_t", 32'(Dis_tag1), 7);
    adv();
    idle(); Dis_rs1 = 3; cmt(3, 7, 32'hDEADBEEF); look();
    chk("byp_b", 32'(Dis_busy1), 0); chk("byp_v", Dis_val1, 32'hDEADBEEF);
    adv();
    idle(); Dis_rs1 = 3; look();
    chk("cmt_b", 32'(Dis_busy1), 0); chk("cmt_v", Dis_val1, 32'hDEADBEEF);
    adv();
    idle(); ren(4, 2); tick();
    idle(); ren(4, 5); tick();
    idle(); cmt(4, 2, 32'h11); Dis_rs1 = 4; look();
    chk("stale_nobyp_b", 32'(Dis_busy1), 1); chk("stale_nobyp_v", Dis_val1, 0);
    adv();
    idle(); Dis_rs1 = 4; look();
    chk("stale_b", 32'(Dis_busy1), 1); chk("stale_t", 32'(Dis_tag1), 5); chk("stale_v", Dis_val1, 32'h11);
    adv();
    idle(); ren(6, 1); tick();
    idle(); ren(6, 9); cmt(6, 1, 32'h66); tick();
    idle(); Dis_rs1 = 6; look();
    chk("race_b", 32'(Dis_busy1), 1); chk("race_t", 32'(Dis_tag1), 9); chk("race_v", Dis_val1, 32'h66);
    adv();
    for (int i = 1; i <= 3; i++) begin idle(); ren(5'(i), TW'(i)); tick(); end
    idle(); ROB_roll = 1; cmt(1, 1, 32'h40); ren(8, 4); tick();
    idle(); Dis_rs1 = 1; Dis_rs2 = 8; look();
    chk("roll_b1", 32'(Dis_busy1), 0); chk("roll_v1", Dis_val1, 32'h40); chk("roll_b8", 32'(Dis_busy2), 0);
    adv();
    idle(); Dis_rs1 = 2; Dis_rs2 = 3; look();
    chk("roll_b2", 32'(Dis_busy1), 0); chk("roll_b3", 32'(Dis_busy2), 0);
    adv();
    idle(); ren(0, 3); cmt(0, 0, 32'h55); tick();
    idle(); Dis_rs1 = 0; look();
    chk("x0_b", 32'(Dis_busy1), 0); chk("x0_v", Dis_val1, 0);
    adv();
    idle(); rdy = 0; ren(9, 6); cmt(10, 0, 32'h77); tick();
    idle(); Dis_rs1 = 9; Dis_rs2 = 10; look();
    chk("frz_b9", 32'(Dis_busy1), 0); chk("frz_v10", Dis_val2, 0);
    adv();
    idle(); ren(11, 1); tick();
    idle(); ren(12, 2); tick();
    idle(); rst = 0; tick();
    rst = 1; idle(); Dis_rs1 = 11; Dis_rs2 = 3; look();
    chk("mrst_b11", 32'(Dis_busy1), 0); chk("mrst_v3", Dis_val2, 0);
    adv();
    for (int i = 0; i < 3000; i++) begin
      rst           = $urandom_range(99) != 0;
      rdy           = $urandom_range(9) != 0;
      Dis_flag      = 1'($urandom_range(1));
      Dis_rd_flag   = $urandom_range(3) != 0;
      Dis_rd        = $urandom_range(3) == 0 ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      Dis_ROB_idx   = TW'($urandom);
      RF_write_flag = 1'($urandom_range(1));
      RF_rd         = 5'($urandom_range(7));
      RF_ROB_idx    = $urandom_range(2) != 0 ? m_tag[RF_rd] : TW'($urandom);
      RF_val        = $urandom;
      ROB_roll      = $urandom_range(24) == 0;
      Dis_rs1       = $urandom_range(2) == 0 ? RF_rd : 5'($urandom_range(7));
      Dis_rs2       = $urandom_range(3) == 0 ? Dis_rd : 5'($urandom_range(31));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file plus per-register rename table; the receiving end of the ROB commit write port (RF_write_flag/RF_rd/RF_ROB_idx/RF_val) and of the ROB rollback signal.
- Dispatch side: marks a destination register busy with its ROB tag, and reads source operands as either a committed value or a pending ROB tag.
- Sits between decoder/dispatch and ROB; dispatch uses the returned tag to query ROB readiness.

Parameters:
- REG_NUM, 32, number of architectural registers; index width 5.
- ROB_IDX_W, 4, ROB tag width (ROB of 16 entries).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global ready; low = freeze all state
- Dis_flag  in  1  dispatch allocating an instruction this cycle
- Dis_rd_flag  in  1  dispatched instruction writes rd
- Dis_rd  in  5  destination register
- Dis_ROB_idx  in  ROB_IDX_W  ROB tag allocated to it
- Dis_rs1  in  5  source register 1
- Dis_rs2  in  5  source register 2
- Dis_busy1  out  1  rs1 pending in ROB
- Dis_tag1  out  ROB_IDX_W  ROB tag for rs1 (valid when busy1)
- Dis_val1  out  32  rs1 value (valid when !busy1)
- Dis_busy2  out  1  same for rs2
- Dis_tag2  out  ROB_IDX_W  same for rs2
- Dis_val2  out  32  same for rs2
- RF_write_flag  in  1  ROB commit write
- RF_rd  in  5  commit destination
- RF_ROB_idx  in  ROB_IDX_W  tag of committing entry
- RF_val  in  32  commit value
- ROB_roll  in  1  misprediction flush

Behaviour:
- State: val[0..31] (32b), busy[0..31], tag[0..31]. On rst==0 at posedge: all cleared to 0. Outputs are combinational, so after reset busy=0, tag=0, val=0 for every source.
- rdy==0 (rst high): no state change; reads stay combinational.
- Read path (combinational, per source rsN):
  - rsN==0: busy=0, tag=0, val=0.
  - Commit bypass: if RF_write_flag && RF_rd==rsN && busy[rsN] && tag[rsN]==RF_ROB_idx, then busy=0, val=RF_val.
  - Otherwise busy=busy[rsN], tag=tag[rsN], val=val[rsN].
  - Reads never see the same-cycle rename. Example: addi x1,x1,1 reads the old x1 mapping.
- Commit (posedge, rdy && RF_write_flag && RF_rd!=0):
  - val[RF_rd] <= RF_val, always, regardless of tag.
  - busy[RF_rd] <= 0 only if tag[RF_rd]==RF_ROB_idx and no same-cycle rename of RF_rd. A younger mapping stays busy.
- Rename (posedge, rdy && Dis_flag && Dis_rd_flag && Dis_rd!=0 && !ROB_roll): busy[Dis_rd] <= 1, tag[Dis_rd] <= Dis_ROB_idx. Rename wins over a commit-clear on the same register.
- Roll (posedge, rdy && ROB_roll):
  - All busy <= 0; tags are left stale and unused.
  - A commit in the same cycle still writes val (JALR commit pairs write with roll).
  - Dispatch rename is ignored.
- x0: never written, never busy.
- No internal FSM beyond the per-register busy bit. Latency: a rename or commit is visible on reads the cycle after the edge; commit is also visible same-cycle via the bypass.

Test Plan:
- Reset: rst=0 one cycle, then rst=1. Read rs1=5, rs2=31 → busy=0, val=0 for both.
- Rename then commit: cycle0 Dis rd=3 tag=7. Cycle1 read rs1=3 → busy1=1, tag1=7. Cycle2 commit rd=3 idx=7 val=0xDEADBEEF → same-cycle read busy1=0, val1=0xDEADBEEF. Cycle3 → busy1=0 from state.
- Stale commit: rename x4→tag2, then x4→tag5; commit rd=4 idx=2 val=0x11 → val[4]=0x11, busy[4]=1, tag[4]=5. The bypass is not taken for tag mismatch.
- Same-cycle rename and commit on x6: tag[6]=1, then commit idx=1 with rename x6→tag9 → busy[6]=1, tag[6]=9, val[6]=commit value.
- Roll: x1,x2,x3 busy, then ROB_roll=1 with commit rd=1 val=0x40 and Dis rd=8 → all busy=0, val[1]=0x40, x8 not busy.
- x0/rdy: rename rd=0 → x0 stays not busy, val 0. With rdy=0, rename x9 and commit x10 → no state change. Reset asserted mid-sequence with busy regs → all cleared next cycle.
